// File: rtl/multi_cdb_reservation_station_pkg.sv
// Shared constants and helpers for the multi-CDB reservation station.
package tomasulo_rs_pkg;

  // Tag value meaning "operand value already present".
  localparam int NO_TAG = 0;

  // LSB position of element idx inside a flattened bus of width-wide elements.
  function automatic int op_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/multi_cdb_reservation_station_age_matrix.sv
// Age bit matrix: older_q[i][j] = 1 means entry i was allocated before entry j.
// Grants the single oldest entry among the ready mask.
module rs_age_matrix #(
  parameter int NUM_RS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_RS-1:0] alloc_i,
  input  logic [NUM_RS-1:0] free_i,
  input  logic [NUM_RS-1:0] ready_i,
  output logic [NUM_RS-1:0] grant_o
);

  logic [NUM_RS-1:0] older_q [NUM_RS];
  logic [NUM_RS-1:0] older_d [NUM_RS];
  logic              blocked;

  // A new entry is younger than everything present; a freed entry claims no seniority.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < NUM_RS; i++) begin
      if (free_i[i]) older_d[i] = '0;
    end
    for (int i = 0; i < NUM_RS; i++) begin
      if (alloc_i[i]) begin
        older_d[i] = '0;
        for (int j = 0; j < NUM_RS; j++) begin
          if (j != i) older_d[j][i] = 1'b1;
        end
      end
    end
  end

  // Age matrix register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RS; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  // An entry wins when no other ready entry is older than it.
  always_comb begin
    grant_o = '0;
    blocked = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < NUM_RS; j++) begin
        if (j != i && ready_i[j] && older_q[j][i]) blocked = 1'b1;
      end
      grant_o[i] = ready_i[i] & ~blocked;
    end
  end

endmodule

// File: rtl/multi_cdb_reservation_station.sv
// Tomasulo reservation station with several snooped CDBs, oldest-ready issue
// and speculative-entry flush on branch mispredict.
module multi_cdb_reservation_station
  import tomasulo_rs_pkg::*;
#(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_OPCODE         = 3,
  parameter int NUM_OPERAND       = 2,
  parameter int NUM_RS            = 4,
  parameter int BW_TAG            = 3,
  parameter int NUM_CDB           = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_iq_valid,
  output logic                                   i_iq_ready,
  input  logic [BW_OPCODE-1:0]                   i_iq_opcode,
  input  logic [NUM_OPERAND*BW_TAG-1:0]          i_iq_Q_flatten,
  input  logic [NUM_OPERAND*BW_PROCESSOR_DATA-1:0] i_iq_V_flatten,
  input  logic [BW_TAG-1:0]                      i_iq_tag,
  input  logic                                   i_iq_speculation,
  input  logic                                   i_branch_valid,
  input  logic                                   i_branch_correct_prediction,
  input  logic [NUM_CDB-1:0]                     i_cdb_valid,
  input  logic [NUM_CDB*BW_TAG-1:0]              i_cdb_tag_flatten,
  input  logic [NUM_CDB*BW_PROCESSOR_DATA-1:0]   i_cdb_data_flatten,
  output logic                                   o_exe_valid,
  input  logic                                   o_exe_ready,
  output logic [BW_OPCODE-1:0]                   o_exe_opcode,
  output logic [BW_TAG-1:0]                      o_exe_tag,
  output logic [NUM_OPERAND*BW_PROCESSOR_DATA-1:0] o_exe_V_flatten,
  output logic [$clog2(NUM_RS+1)-1:0]            o_count
);

  localparam int BW_CNT = $clog2(NUM_RS+1);
  localparam int D      = BW_PROCESSOR_DATA;

  logic [NUM_RS-1:0]    busy_q, busy_d, spec_q, spec_d;
  logic [BW_OPCODE-1:0] opc_q [NUM_RS];
  logic [BW_OPCODE-1:0] opc_d [NUM_RS];
  logic [BW_TAG-1:0]    tag_q [NUM_RS];
  logic [BW_TAG-1:0]    tag_d [NUM_RS];
  logic [BW_TAG-1:0]    q_q   [NUM_RS][NUM_OPERAND];
  logic [BW_TAG-1:0]    q_d   [NUM_RS][NUM_OPERAND];
  logic [D-1:0]         v_q   [NUM_RS][NUM_OPERAND];
  logic [D-1:0]         v_d   [NUM_RS][NUM_OPERAND];

  logic [BW_TAG-1:0]    in_q     [NUM_OPERAND];
  logic [D-1:0]         in_v     [NUM_OPERAND];
  logic [BW_TAG-1:0]    cdb_tag  [NUM_CDB];
  logic [D-1:0]         cdb_data [NUM_CDB];

  logic [NUM_RS-1:0] alloc_oh, alloc_en, ready, grant, issue_free;
  logic              found, flush, br_ok, do_alloc, keep_alloc, fire;
  logic [BW_CNT-1:0] count;

  // Unpack flattened dispatch and broadcast buses.
  always_comb begin
    for (int k = 0; k < NUM_OPERAND; k++) begin
      in_q[k] = i_iq_Q_flatten[op_lsb(k, BW_TAG) +: BW_TAG];
      in_v[k] = i_iq_V_flatten[op_lsb(k, D) +: D];
    end
    for (int b = 0; b < NUM_CDB; b++) begin
      cdb_tag[b]  = i_cdb_tag_flatten[op_lsb(b, BW_TAG) +: BW_TAG];
      cdb_data[b] = i_cdb_data_flatten[op_lsb(b, D) +: D];
    end
  end

  // Occupancy, free-slot pick, ready mask and handshake qualifiers.
  always_comb begin
    count    = '0;
    alloc_oh = '0;
    found    = 1'b0;
    ready    = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      count = count + BW_CNT'(busy_q[i]);
      if (!busy_q[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
    flush      = i_branch_valid & ~i_branch_correct_prediction;
    br_ok      = i_branch_valid & i_branch_correct_prediction;
    i_iq_ready = (count != BW_CNT'(NUM_RS));
    do_alloc   = i_iq_valid & i_iq_ready;
    keep_alloc = do_alloc & ~(flush & i_iq_speculation);
    alloc_en   = keep_alloc ? alloc_oh : '0;
    for (int i = 0; i < NUM_RS; i++) begin
      ready[i] = busy_q[i] & ~(flush & spec_q[i]);
      for (int k = 0; k < NUM_OPERAND; k++) begin
        if (q_q[i][k] != BW_TAG'(NO_TAG)) ready[i] = 1'b0;
      end
    end
    o_exe_valid = |ready;
    fire        = o_exe_valid & o_exe_ready;
    issue_free  = fire ? grant : '0;
    o_count     = count;
  end

  rs_age_matrix #(.NUM_RS(NUM_RS)) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .alloc_i (alloc_en),
    .free_i  (issue_free),
    .ready_i (ready),
    .grant_o (grant)
  );

  // Entry next state: wake-up, issue free, branch resolve, then dispatch write.
  // Bus scans run high-to-low so the lowest matching bus wins.
  always_comb begin
    busy_d = busy_q;
    spec_d = spec_q;
    opc_d  = opc_q;
    tag_d  = tag_q;
    q_d    = q_q;
    v_d    = v_q;
    for (int i = 0; i < NUM_RS; i++) begin
      for (int k = 0; k < NUM_OPERAND; k++) begin
        for (int b = NUM_CDB-1; b >= 0; b--) begin
          if (busy_q[i] && i_cdb_valid[b] && q_q[i][k] != BW_TAG'(NO_TAG) &&
              cdb_tag[b] == q_q[i][k]) begin
            q_d[i][k] = BW_TAG'(NO_TAG);
            v_d[i][k] = cdb_data[b];
          end
        end
      end
    end
    busy_d = busy_d & ~issue_free;
    if (br_ok) spec_d = '0;
    if (flush) busy_d = busy_d & ~spec_q;
    for (int i = 0; i < NUM_RS; i++) begin
      if (alloc_en[i]) begin
        busy_d[i] = 1'b1;
        spec_d[i] = i_iq_speculation & ~br_ok;
        opc_d[i]  = i_iq_opcode;
        tag_d[i]  = i_iq_tag;
        for (int k = 0; k < NUM_OPERAND; k++) begin
          q_d[i][k] = in_q[k];
          v_d[i][k] = in_v[k];
          for (int b = NUM_CDB-1; b >= 0; b--) begin
            if (i_cdb_valid[b] && in_q[k] != BW_TAG'(NO_TAG) && cdb_tag[b] == in_q[k]) begin
              q_d[i][k] = BW_TAG'(NO_TAG);
              v_d[i][k] = cdb_data[b];
            end
          end
        end
      end
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      spec_q <= '0;
      for (int i = 0; i < NUM_RS; i++) begin
        opc_q[i] <= '0;
        tag_q[i] <= '0;
        for (int k = 0; k < NUM_OPERAND; k++) begin
          q_q[i][k] <= '0;
          v_q[i][k] <= '0;
        end
      end
    end else begin
      busy_q <= busy_d;
      spec_q <= spec_d;
      opc_q  <= opc_d;
      tag_q  <= tag_d;
      q_q    <= q_d;
      v_q    <= v_d;
    end
  end

  // Issue payload: AND-OR of the one-hot grant, zero when nothing is ready.
  always_comb begin
    o_exe_opcode    = '0;
    o_exe_tag       = '0;
    o_exe_V_flatten = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      o_exe_opcode = o_exe_opcode | (opc_q[i] & {BW_OPCODE{grant[i]}});
      o_exe_tag    = o_exe_tag | (tag_q[i] & {BW_TAG{grant[i]}});
      for (int k = 0; k < NUM_OPERAND; k++) begin
        o_exe_V_flatten[op_lsb(k, D) +: D] = o_exe_V_flatten[op_lsb(k, D) +: D] |
                                             (v_q[i][k] & {D{grant[i]}});
      end
    end
  end

endmodule
